pattern_scan_ctrl: RTL and testbench

Hardware engine that performs the program-3 pattern search directly on data memory. On `req` it reads the 5-bit pattern from address 32 and scans bytes 0–31. It then writes three counts to addresses 33, 34 and 35 and raises `done`. It sits beside the core in `top_level` and owns the data-memory port while `busy` is high; `top_level` muxes the `dm1` port to it.

---
 rtl/scan_pkg.sv | 20 ++
 rtl/pattern_scan_ctrl_if.sv | 30 +++
 rtl/pattern_match_unit.sv | 36 +++
 rtl/pattern_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared types and default constants for the pattern scan engine.
package scan_pkg;

  localparam int         PAT_W        = 5;
  localparam int         IDX_W        = 6;
  localparam int         N_BYTES_DEF  = 32;
  localparam logic [7:0] PAT_ADDR_DEF = 8'd32;
  localparam logic [7:0] RES_ADDR_DEF = 8'd33;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_PAT = 3'd1,
    S_SCAN     = 3'd2,
    S_WR_CTB   = 3'd3,
    S_WR_CTO   = 3'd4,
    S_WR_CTS   = 3'd5,
    S_DONE     = 3'd6
  } scan_state_t;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Control and data-memory port of the pattern scan engine.
//
// Handshake: req is a start request sampled only while the engine is idle
// (IDLE or DONE); any req seen while busy is dropped. done stays high from
// completion until the next accepted req. The memory side is a single port:
// mem_rd_data is an asynchronous read of mem_addr in the same cycle, and a
// cycle with mem_wr_en=1 commits mem_wr_data to mem_addr on the next edge.
interface pattern_scan_ctrl_if;
  import scan_pkg::*;

  logic        req;
  logic        done;
  logic        busy;
  logic [7:0]  mem_addr;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data;
  scan_state_t dbg_state;

  modport master (
    input  req, mem_rd_data,
    output done, busy, mem_addr, mem_wr_en, mem_wr_data, dbg_state
  );

  modport slave (
    output req, mem_rd_data,
    input  done, busy, mem_addr, mem_wr_en, mem_wr_data, dbg_state
  );

endinterface

// File: rtl/pattern_match_unit.sv
// Combinational 5-bit window matcher for one scanned byte.
// intra_cnt : windows fully inside cur (4 positions).
// cross_cnt : windows whose last bit lies in cur (8 positions, reaching into
//             prev[3:0]); for the first byte there is no previous byte, so it
//             falls back to the intra count.
module pattern_match_unit
  import scan_pkg::*;
(
  input  logic [PAT_W-1:0] pat,
  input  logic [3:0]       prev,
  input  logic [7:0]       cur,
  input  logic             first,
  output logic [2:0]       intra_cnt,
  output logic             any_match,
  output logic [3:0]       cross_cnt
);

  logic [11:0] w;

  assign w = {prev, cur};

  // Count matching windows inside the byte and across the byte boundary.
  always_comb begin
    intra_cnt = '0;
    cross_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      if (cur[k +: PAT_W] == pat) intra_cnt = intra_cnt + 3'd1;
    end
    for (int k = 0; k < 8; k++) begin
      if (w[k +: PAT_W] == pat) cross_cnt = cross_cnt + 4'd1;
    end
    if (first) cross_cnt = {1'b0, intra_cnt};
    any_match = (intra_cnt != 3'd0);
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Pattern scan engine: loads a 5-bit pattern, scans N_BYTES bytes of data
// memory, and writes the byte-internal, byte-hit and full-string counts.
module pattern_scan_ctrl
  import scan_pkg::*;
#(
  parameter int         N_BYTES  = N_BYTES_DEF,
  parameter logic [7:0] PAT_ADDR = PAT_ADDR_DEF,
  parameter logic [7:0] RES_ADDR = RES_ADDR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  pattern_scan_ctrl_if.master bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [PAT_W-1:0] pat_q;
  logic [3:0]       prev_q;
  logic [7:0]       ctb_q, cto_q, cts_q;

  logic [2:0]       intra_cnt;
  logic             any_match;
  logic [3:0]       cross_cnt;
  logic             idle_like;

  assign idle_like     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.busy      = !idle_like;
  assign bus.dbg_state = state_q;

  pattern_match_unit u_match (
    .pat       (pat_q),
    .prev      (prev_q),
    .cur       (bus.mem_rd_data),
    .first     (idx_q == '0),
    .intra_cnt (intra_cnt),
    .any_match (any_match),
    .cross_cnt (cross_cnt)
  );

  // State register; reset returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and memory-port decode from the current state and index.
  always_comb begin
    state_d         = state_q;
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.req) state_d = S_LOAD_PAT;
      end
      S_LOAD_PAT: begin
        bus.mem_addr = PAT_ADDR;
        state_d      = S_SCAN;
      end
      S_SCAN: begin
        bus.mem_addr = 8'(idx_q);
        if (idx_q == LAST_IDX) state_d = S_WR_CTB;
      end
      S_WR_CTB: begin
        bus.mem_addr    = RES_ADDR;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = ctb_q;
        state_d         = S_WR_CTO;
      end
      S_WR_CTO: begin
        bus.mem_addr    = RES_ADDR + 8'd1;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = cto_q;
        state_d         = S_WR_CTS;
      end
      S_WR_CTS: begin
        bus.mem_addr    = RES_ADDR + 8'd2;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = cts_q;
        state_d         = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: pattern latch, byte index, previous nibble and the counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q  <= '0;
      pat_q  <= '0;
      prev_q <= '0;
      ctb_q  <= '0;
      cto_q  <= '0;
      cts_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.req) begin
            idx_q <= '0;
            ctb_q <= '0;
            cto_q <= '0;
            cts_q <= '0;
          end
        end
        S_LOAD_PAT: begin
          pat_q <= bus.mem_rd_data[7:3];
          idx_q <= '0;
        end
        S_SCAN: begin
          ctb_q  <= ctb_q + {5'd0, intra_cnt};
          cto_q  <= cto_q + {7'd0, any_match};
          cts_q  <= cts_q + {4'd0, cross_cnt};
          prev_q <= bus.mem_rd_data[3:0];
          idx_q  <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: memory model, directed and random scans
// compared with a bit-string reference count.
module tb_pattern_scan_ctrl;
  import scan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_scan_ctrl_if bus ();

  pattern_scan_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- memory model ----------------
  logic [7:0] data_mem [0:63];
  logic [7:0] res_mem  [0:2];
  logic       res_clear;
  int         wr_cnt;
  int         bad_wr = 0;

  int vectors     = 0;
  int miscompares = 0;

  always_comb begin
    bus.mem_rd_data = 8'h00;
    if (bus.mem_addr <= 8'd32)      bus.mem_rd_data = data_mem[bus.mem_addr[5:0]];
    else if (bus.mem_addr == 8'd33) bus.mem_rd_data = res_mem[0];
    else if (bus.mem_addr == 8'd34) bus.mem_rd_data = res_mem[1];
    else if (bus.mem_addr == 8'd35) bus.mem_rd_data = res_mem[2];
  end

  always @(posedge clk) begin
    if (res_clear) begin
      res_mem[0] <= 8'hA5;
      res_mem[1] <= 8'hA5;
      res_mem[2] <= 8'hA5;
      wr_cnt     <= 0;
    end else if (bus.mem_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      case (bus.mem_addr)
        8'd33:   res_mem[0] <= bus.mem_wr_data;
        8'd34:   res_mem[1] <= bus.mem_wr_data;
        8'd35:   res_mem[2] <= bus.mem_wr_data;
        default: bad_wr     <= bad_wr + 1;
      endcase
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: treat bytes 0..31 as one 256-bit string, byte 0 MSB first,
  // and count every 5-bit window in it.
  task automatic model(input logic [4:0] p, output logic [7:0] e_ctb,
                       output logic [7:0] e_cto, output logic [7:0] e_cts);
    logic       s [256];
    logic [4:0] v;
    logic       hit_byte [32];
    e_ctb = 0;
    e_cto = 0;
    e_cts = 0;
    for (int i = 0; i < 32; i++) begin
      hit_byte[i] = 1'b0;
      for (int j = 0; j < 8; j++) s[8*i + j] = data_mem[i][7-j];
    end
    for (int t = 0; t < 252; t++) begin
      for (int q = 0; q < 5; q++) v[4-q] = s[t + q];
      if (v == p) begin
        e_cts++;
        if ((t % 8) <= 3) begin
          e_ctb++;
          hit_byte[t / 8] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 32; i++) if (hit_byte[i]) e_cto++;
  endtask

  task automatic fill_const(input logic [7:0] b);
    for (int i = 0; i < 32; i++) data_mem[i] = b;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 32; i++) data_mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic clear_results();
    @(negedge clk) res_clear = 1'b1;
    @(negedge clk) res_clear = 1'b0;
  endtask

  // Wait for done with a bound; counts edges after the accepting edge.
  task automatic wait_done(input int poke, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      bus.req = (cycles == poke);
    end while (bus.done !== 1'b1 && cycles < 100);
    bus.req = 1'b0;
  endtask

  // One complete scan from IDLE/DONE; poke>0 raises req again mid-scan.
  task automatic run_scan(input string name, input logic [4:0] p, input int poke);
    logic [7:0] e_ctb, e_cto, e_cts;
    int         cycles;
    data_mem[32] = {p, 3'($urandom_range(0, 7))};
    model(p, e_ctb, e_cto, e_cts);
    clear_results();
    @(negedge clk) bus.req = 1'b1;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    check({name, " busy_after_req"}, bus.busy, 1);
    check({name, " done_drop"}, bus.done, 0);
    wait_done(poke, cycles);
    check({name, " latency"}, cycles, 36);
    check({name, " ctb"}, res_mem[0], e_ctb);
    check({name, " cto"}, res_mem[1], e_cto);
    check({name, " cts"}, res_mem[2], e_cts);
    check({name, " writes"}, wr_cnt, 3);
    check({name, " busy_end"}, bus.busy, 0);
  endtask

  task automatic check_res(input string name, input int a, input int b, input int c);
    check({name, " ctb_const"}, res_mem[0], a);
    check({name, " cto_const"}, res_mem[1], b);
    check({name, " cts_const"}, res_mem[2], c);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cycles;
    bus.req   = 1'b0;
    res_clear = 1'b1;
    reset     = 1'b0;
    for (int i = 0; i < 64; i++) data_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst done", bus.done, 0);
    check("rst busy", bus.busy, 0);
    check("rst wr_en", bus.mem_wr_en, 0);
    check("rst addr", bus.mem_addr, 0);
    check("rst wdata", bus.mem_wr_data, 0);
    check("rst state", bus.dbg_state, S_IDLE);
    @(negedge clk);
    reset     = 1'b1;
    res_clear = 1'b0;

    fill_const(8'h00); run_scan("zeros_p0", 5'b00000, 0); check_res("zeros_p0", 128, 32, 252);
    fill_const(8'h55); run_scan("x55_p21", 5'b10101, 0);  check_res("x55_p21", 64, 32, 126);
    fill_const(8'hFF); run_scan("ones_p31", 5'b11111, 0); check_res("ones_p31", 128, 32, 252);
    fill_const(8'h00); run_scan("zeros_p31", 5'b11111, 0); check_res("zeros_p31", 0, 0, 0);
    fill_const(8'h00); data_mem[0] = 8'hF8;
    run_scan("f8_p31", 5'b11111, 0); check_res("f8_p31", 1, 1, 1);
    fill_const(8'h00); data_mem[0] = 8'h03; data_mem[1] = 8'hE0;
    run_scan("cross_p31", 5'b11111, 0); check_res("cross_p31", 0, 0, 1);

    // req pulsed while scanning idx=5 must be ignored
    fill_rand(); run_scan("busy_req", 5'($urandom_range(0, 31)), 6);

    // randomized scans, some with dense patterns to raise hit counts
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0) fill_rand();
      else for (int i = 0; i < 32; i++) data_mem[i] = ($urandom_range(0, 1) != 0) ? 8'h55 : 8'($urandom_range(0, 255));
      run_scan("random", 5'($urandom_range(0, 31)), 0);
    end

    // reset during SCAN at idx=10, with a simultaneous req
    fill_rand();
    data_mem[32] = {5'($urandom_range(0, 31)), 3'b000};
    clear_results();
    @(negedge clk) bus.req = 1'b1;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("mid state", bus.dbg_state, S_SCAN);
    reset   = 1'b0;
    bus.req = 1'b1;
    @(posedge clk);
    #1;
    check("rst2 state", bus.dbg_state, S_IDLE);
    check("rst2 busy", bus.busy, 0);
    check("rst2 done", bus.done, 0);
    check("rst2 wr_en", bus.mem_wr_en, 0);
    check("rst2 addr", bus.mem_addr, 0);
    check("rst2 wdata", bus.mem_wr_data, 0);
    bus.req = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    check("rst2 res0", res_mem[0], 8'hA5);
    check("rst2 res1", res_mem[1], 8'hA5);
    check("rst2 res2", res_mem[2], 8'hA5);
    check("rst2 writes", wr_cnt, 0);
    run_scan("after_rst", 5'($urandom_range(0, 31)), 0);

    // req held high in DONE restarts the scan each time DONE is reached
    @(negedge clk) bus.req = 1'b1;
    @(posedge clk);
    #1;
    check("hold busy", bus.busy, 1);
    repeat (36) @(posedge clk);
    #1;
    check("hold done", bus.done, 1);
    @(posedge clk);
    #1;
    check("hold restart", bus.busy, 1);
    check("hold done_drop", bus.done, 0);
    bus.req = 1'b0;
    wait_done(0, cycles);
    check("hold latency", cycles, 36);

    check("stray writes", bad_wr, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
